enemy_fire_sched: RTL
=====================

# enemy_fire_sched

Parametrised enemy fire scheduler for the invaders game engine. Every `fire_period` cycles while the game is running it picks a pseudo-random starting enemy from a 16-bit LFSR, scans forward with wrap-around to the first live enemy, and requests a shot from the bullet unit through a req/ack handshake. It replaces the fixed-index shooter selection in the top-level engine. All-dead, game-over and restart cases are handled explicitly.

## Interface
- `N_ENEMY`, 6: number of enemies; must be at least 2.
- `ID_W`, $clog2(N_ENEMY): width of the enemy index.
- `DELAY_W`, 20: width of the fire-period counter.
- `LFSR_SEED`, 16'hACE1: LFSR reset/restart value; must be nonzero.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous game restart, active-high.
- `estado_jogo`  in  2  game state: 0 = running, 1 = player won, 2 = player lost.
- `enemy_vivos`  in  N_ENEMY  live mask; bit i set means enemy i is alive.
- `fire_period`  in  DELAY_W  cycles between shot attempts; a value of 0 is treated as 1.
- `shot_ack`  in  1  bullet unit accepted the shot.
- `shot_req`  out  1  shot request.
- `shot_id`  out  ID_W  index of the shooting enemy.
- `shot_onehot`  out  N_ENEMY  one-hot form of `shot_id`; all zero when `shot_req` is 0.

## Operation
- The LFSR is a 16-bit Galois LFSR with mask 16'hB400, shifting right.
  - It advances every cycle, including while the game is not running.
  - Reset and `restart` load `LFSR_SEED`.
- FSM states are WAIT, PICK, SCAN and REQ. Reset state is WAIT with `cnt`=0, `idx`=0 and `scan_cnt`=0.
- WAIT:
  - `cnt` increments only while `estado_jogo`==0.
  - When `cnt`==max(`fire_period`,1)-1: clear `cnt` and go to PICK.
- PICK:
  - `idx` = `lfsr[ID_W-1:0]`; subtract `N_ENEMY` once if the result is ≥ `N_ENEMY`.
  - Clear `scan_cnt` and go to SCAN.
- SCAN: each cycle, test `enemy_vivos[idx]`.
  - Alive: go to REQ.
  - Dead: `idx` = (`idx`==N_ENEMY-1) ? 0 : `idx`+1, and `scan_cnt`++.
  - If `scan_cnt` reaches N_ENEMY-1 and the enemy is still dead: go to WAIT; no shot is issued.
- REQ:
  - `shot_req`=1, with `shot_id`=`idx` and `shot_onehot`=1<<`idx`.
  - Outputs hold stable until the first cycle with `shot_ack`=1.
  - The transfer completes in that ack cycle and the FSM returns to WAIT with `cnt`=0.
  - The request is held even if that enemy dies meanwhile; the bullet unit filters.
- `shot_ack` is ignored outside REQ.
- Abort rule: if `estado_jogo`≠0 or `restart`=1, the next state is WAIT from any state.
  - `cnt` is cleared and `shot_req` drops the next cycle. An in-flight request is abandoned.
  - `restart` has priority over `shot_ack` in the same cycle: the transfer does not complete.
- A change of `fire_period` takes effect on the next compare. If the new value is ≤ `cnt`, the counter runs to wrap at 2^DELAY_W.

## Timing
- All outputs are registered.
- Reset values: `shot_req`=0, `shot_id`=0, `shot_onehot`=0.
- Latency, measured from the WAIT entry with `cnt`=0 (cycle 0) to `shot_req` high: P+2+k cycles.
  - P is the effective period.
  - k is the number of dead enemies skipped, 0..N_ENEMY-1.
- The all-dead case costs 1+N_ENEMY cycles after PICK, then WAIT restarts.
- Minimum gap between accepted shots is P+2 cycles.
- Asynchronous reset takes effect mid-request immediately; `shot_req` falls without waiting for a clock.

## Structure
- Shared package `engine_pkg` holds:
  - the `fire_state_t` enum (WAIT, PICK, SCAN, REQ);
  - `LFSR_MASK` = 16'hB400;
  - estado_jogo constants `JOGO_RODANDO`=0, `JOGO_VITORIA`=1, `JOGO_DERROTA`=2.
- One sub-module, `lfsr16`, with ports `clk`, `reset`, `load`, `seed` and `q`.
- The FSM, counter and scan logic live in `enemy_fire_sched`.

## Test plan
- **Single live enemy.** Stimulus: N_ENEMY=6, `fire_period`=4, `enemy_vivos`=6'b000100, `shot_ack` tied high. Required: `shot_id`=2 and `shot_onehot`=6'b000100 on every shot. Shot spacing is 4+2+k cycles, where k depends on the LFSR start.
- **All dead.** Stimulus: `enemy_vivos`=0 for 100 cycles. Required: `shot_req` never asserts, and the FSM cycles WAIT→PICK→SCAN(6 cycles)→WAIT.
- **Held request.** Stimulus: hold `shot_ack`=0 for 10 cycles in REQ, and kill that enemy during the hold. Required: `shot_req`, `shot_id` and `shot_onehot` stay stable. Ack on cycle 11 returns the FSM to WAIT with `cnt`=0.
- **Game over and restart.** Stimulus: `estado_jogo`=2 during REQ. Required: `shot_req` falls the next cycle and `cnt` stays 0 while `estado_jogo`≠0. Separately, `restart` pulsed with `shot_ack`=1: no transfer completes, and the LFSR equals `LFSR_SEED` the cycle after.
- **Async reset mid-scan.** Stimulus: assert `reset`=0 between clock edges. Required: all outputs are 0 immediately.
- **Coverage.** Stimulus: 2000 shots with all enemies alive. Required: every `shot_id` 0..5 occurs, and none is below 8% of the shots.

Source files
------------

// File: rtl/engine_pkg.sv
// Shared definitions for the invaders game engine: scheduler FSM states,
// the enemy-fire LFSR feedback mask and the game-state encoding.
package engine_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    PICK = 2'd1,
    SCAN = 2'd2,
    REQ  = 2'd3
  } fire_state_t;

  // Galois feedback mask (taps 16,14,13,11), applied when shifting right
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [1:0] JOGO_RODANDO = 2'd0;
  localparam logic [1:0] JOGO_VITORIA = 2'd1;
  localparam logic [1:0] JOGO_DERROTA = 2'd2;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR. It free-runs every cycle; load forces
// the seed in synchronously, and async reset returns to RST_SEED.
module lfsr16
  import engine_pkg::*;
#(
  parameter logic [15:0] RST_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Next state: reload on load, otherwise one Galois step
  always_comb begin
    q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_MASK : 16'h0000);
    if (load) q_d = seed;
  end

  // LFSR state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= RST_SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/enemy_fire_sched.sv
// Enemy fire scheduler: every fire period it picks a pseudo-random start
// enemy, scans forward (with wrap) to the first live one and requests a
// shot from the bullet unit through a req/ack handshake.
module enemy_fire_sched
  import engine_pkg::*;
#(
  parameter int          N_ENEMY   = 6,
  parameter int          ID_W      = $clog2(N_ENEMY),
  parameter int          DELAY_W   = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic [1:0]         estado_jogo,
  input  logic [N_ENEMY-1:0] enemy_vivos,
  input  logic [DELAY_W-1:0] fire_period,
  input  logic               shot_ack,
  output logic               shot_req,
  output logic [ID_W-1:0]    shot_id,
  output logic [N_ENEMY-1:0] shot_onehot
);

  fire_state_t        state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]    idx_q, idx_d;
  logic [ID_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic               shot_req_q;
  logic [ID_W-1:0]    shot_id_q;
  logic [N_ENEMY-1:0] shot_onehot_q;

  logic [15:0]        lfsr_q;
  logic [DELAY_W-1:0] period_eff;
  logic [ID_W-1:0]    pick_raw;
  logic [ID_W-1:0]    pick_idx;
  logic [N_ENEMY-1:0] onehot_d;
  logic               abort;
  logic               unused_lfsr_hi;

  lfsr16 #(
    .RST_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (restart),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Only the low ID_W bits pick the start enemy
  assign unused_lfsr_hi = ^lfsr_q[15:ID_W];

  // Derived values: effective period, folded LFSR pick, abort condition
  always_comb begin
    period_eff = (fire_period == '0) ? DELAY_W'(1) : fire_period;
    abort      = (estado_jogo != JOGO_RODANDO) || restart;
    pick_raw   = lfsr_q[ID_W-1:0];
    // 2^ID_W < 2*N_ENEMY, so a single subtraction always lands in range
    pick_idx   = (int'(pick_raw) >= N_ENEMY) ? pick_raw - ID_W'(N_ENEMY) : pick_raw;
  end

  // FSM next-state: period count, pick, forward scan, handshake, abort
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    scan_cnt_d = scan_cnt_q;
    case (state_q)
      WAIT: begin
        if (cnt_q == period_eff - DELAY_W'(1)) begin
          cnt_d   = '0;
          state_d = PICK;
        end else begin
          // a period shrunk below cnt runs on to the natural wrap
          cnt_d = cnt_q + DELAY_W'(1);
        end
      end
      PICK: begin
        idx_d      = pick_idx;
        scan_cnt_d = '0;
        state_d    = SCAN;
      end
      SCAN: begin
        if (enemy_vivos[idx_q]) begin
          state_d = REQ;
        end else if (scan_cnt_q == ID_W'(N_ENEMY - 1)) begin
          // every enemy tested dead: give up this period
          state_d = WAIT;
        end else begin
          idx_d      = (idx_q == ID_W'(N_ENEMY - 1)) ? '0 : idx_q + ID_W'(1);
          scan_cnt_d = scan_cnt_q + ID_W'(1);
        end
      end
      REQ: begin
        // the request is held even if the target dies; the bullet unit filters
        if (shot_ack) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      default: state_d = WAIT;
    endcase
    // game over / restart wins over everything, including a same-cycle ack
    if (abort) begin
      state_d = WAIT;
      cnt_d   = '0;
    end
  end

  // One-hot form of the index that will be presented next cycle
  always_comb begin
    onehot_d        = '0;
    onehot_d[idx_d] = 1'b1;
  end

  // FSM, counter and scan registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  // Registered shot outputs, driven from the next state so REQ and
  // shot_req line up on the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shot_req_q    <= 1'b0;
      shot_id_q     <= '0;
      shot_onehot_q <= '0;
    end else begin
      shot_req_q <= (state_d == REQ);
      if (state_d == REQ) begin
        shot_id_q     <= idx_d;
        shot_onehot_q <= onehot_d;
      end else begin
        shot_onehot_q <= '0;
      end
    end
  end

  assign shot_req    = shot_req_q;
  assign shot_id     = shot_id_q;
  assign shot_onehot = shot_onehot_q;

endmodule
